// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: arbiter state,
// one-entry pending slot, and the memory-side request/response bundles.
package mem_port_arbiter_pkg;

  localparam int ARB_XLEN = 32;
  localparam int ARB_STRB = ARB_XLEN / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic                instr;
    logic [ARB_XLEN-1:0] addr;
    logic [ARB_XLEN-1:0] wdata;
    logic [ARB_STRB-1:0] wstrb;
  } slot_t;

  localparam slot_t SLOT_INIT = '0;

  typedef struct packed {
    logic                valid;
    logic                instr;
    logic [ARB_XLEN-1:0] addr;
    logic [ARB_XLEN-1:0] wdata;
    logic [ARB_STRB-1:0] wstrb;
  } mem_req_t;

  typedef struct packed {
    logic                ready;
    logic [ARB_XLEN-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/mem_port_slot.sv
// One-entry pending request register: captures a valid pulse, clears on grant.
module mem_port_slot
  import mem_port_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  cap,
  input  logic  clr,
  input  slot_t cap_slot,
  output slot_t slot_q
);

  slot_t slot_d;

  // A grant in the capture cycle means the request was bypassed straight out.
  always_comb begin
    slot_d = slot_q;
    if (clr)      slot_d = SLOT_INIT;
    else if (cap) slot_d = cap_slot;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) slot_q <= SLOT_INIT;
    else      slot_q <= slot_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction and data requesters; one
// transaction in flight, round-robin on contention, one pending slot per port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = ARB_XLEN,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              imem_valid,
  input  logic [XLEN-1:0]   imem_addr,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              imem_ready,
  input  logic              dmem_valid,
  input  logic              dmem_instr,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN/8-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_ready,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);

  // Slot and bundle structs are sized by ARB_XLEN; XLEN must match it.
  slot_t      ibyp, dbyp, icand, dcand, islot_q, dslot_q;
  mem_rsp_t   mem_rsp;
  mem_req_t   req_q, req_d;
  arb_state_e state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       arb_en, grant_i, grant_d;

  assign mem_rsp = '{ready: mem_ready, rdata: mem_rdata};

  // Candidate per port: the pending slot if full, else this cycle's pulse.
  always_comb begin
    ibyp       = SLOT_INIT;
    ibyp.valid = imem_valid;
    ibyp.instr = 1'b1;
    ibyp.addr  = imem_addr;
    dbyp       = '{valid: dmem_valid, instr: dmem_instr, addr: dmem_addr,
                   wdata: dmem_wdata, wstrb: dmem_wstrb};
    icand      = islot_q.valid ? islot_q : ibyp;
    dcand      = dslot_q.valid ? dslot_q : dbyp;
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    req_d     = req_q;
    req_d.valid = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    arb_en    = (state_q == IDLE) || mem_rsp.ready;

    if (state_q != IDLE && mem_rsp.ready) state_d = IDLE;

    if (arb_en) begin
      if (icand.valid && dcand.valid) begin
        grant_d = !last_d_q;
        grant_i = last_d_q;
      end else begin
        grant_i = icand.valid;
        grant_d = dcand.valid;
      end
    end

    if (grant_i) begin
      state_d  = BUSY_I;
      last_d_d = 1'b0;
      req_d    = '{valid: 1'b1, instr: icand.instr, addr: icand.addr,
                   wdata: icand.wdata, wstrb: icand.wstrb};
    end else if (grant_d) begin
      state_d  = BUSY_D;
      last_d_d = 1'b1;
      req_d    = '{valid: 1'b1, instr: dcand.instr, addr: dcand.addr,
                   wdata: dcand.wdata, wstrb: dcand.wstrb};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= !DATA_FIRST;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      req_q    <= req_d;
    end
  end

  mem_port_slot u_islot (
    .clk      (clk),
    .rst      (rst),
    .cap      (imem_valid),
    .clr      (grant_i),
    .cap_slot (ibyp),
    .slot_q   (islot_q)
  );

  mem_port_slot u_dslot (
    .clk      (clk),
    .rst      (rst),
    .cap      (dmem_valid),
    .clr      (grant_d),
    .cap_slot (dbyp),
    .slot_q   (dslot_q)
  );

  assign mem_valid  = req_q.valid;
  assign mem_instr  = req_q.instr;
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign mem_wstrb  = req_q.wstrb;

  assign imem_ready = mem_rsp.ready && (state_q == BUSY_I);
  assign dmem_ready = mem_rsp.ready && (state_q == BUSY_D);
  assign imem_rdata = (state_q == BUSY_I) ? mem_rsp.rdata : '0;
  assign dmem_rdata = (state_q == BUSY_D) ? mem_rsp.rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam bit DF = 1'b1;

  logic        rst, clk;
  logic        imem_valid, imem_ready, dmem_valid, dmem_instr, dmem_ready;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb, mem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.XLEN(32), .DATA_FIRST(DF)) dut (
    .rst(rst), .clk(clk),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: per-port request queues of depth one, the port in
  // flight (0 none, 1 instr, 2 data), who won last, and the issued request.
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } treq_t;

  treq_t pend_i[$], pend_d[$];
  treq_t m_req;
  int    m_busy;
  int    m_last;
  bit    m_mv;

  task automatic m_reset();
    pend_i.delete();
    pend_d.delete();
    m_busy = 0;
    m_last = DF ? 1 : 2;
    m_mv   = 1'b0;
    m_req  = '0;
  endtask

  task automatic idle_inputs();
    imem_valid = 0; imem_addr = 0; dmem_valid = 0; dmem_instr = 0;
    dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 0);
    chk({tag, "_mem_instr"}, {31'd0, mem_instr}, 0);
    chk({tag, "_imem_ready"}, {31'd0, imem_ready}, 0);
    chk({tag, "_dmem_ready"}, {31'd0, dmem_ready}, 0);
    chk({tag, "_imem_rdata"}, imem_rdata, 0);
    chk({tag, "_dmem_rdata"}, dmem_rdata, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_all_zero("rst");
    m_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // One clock: drive at negedge, check outputs, advance the model to the edge.
  task automatic cyc(input bit iv, input logic [31:0] ia, input bit dv,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic [3:0] dws, input bit di, input bit mr,
                     input logic [31:0] mrd);
    treq_t ni, nd;
    int    want_i, want_d, win;
    @(negedge clk);
    imem_valid = iv; imem_addr = ia;
    dmem_valid = dv; dmem_addr = da; dmem_wdata = dwd; dmem_wstrb = dws; dmem_instr = di;
    mem_ready = mr; mem_rdata = mrd;
    #1;
    chk("imem_ready", {31'd0, imem_ready}, {31'd0, mr && m_busy == 1});
    chk("dmem_ready", {31'd0, dmem_ready}, {31'd0, mr && m_busy == 2});
    chk("imem_rdata", imem_rdata, (m_busy == 1) ? mrd : 32'd0);
    chk("dmem_rdata", dmem_rdata, (m_busy == 2) ? mrd : 32'd0);
    chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_mv});
    chk("mem_addr", mem_addr, m_req.addr);
    chk("mem_wdata", mem_wdata, m_req.wdata);
    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_req.wstrb});
    chk("mem_instr", {31'd0, mem_instr}, {31'd0, m_req.instr});

    ni = '{instr: 1'b1, addr: ia, wdata: 32'd0, wstrb: 4'd0};
    nd = '{instr: di, addr: da, wdata: dwd, wstrb: dws};
    if (iv) pend_i.push_back(ni);
    if (dv) pend_d.push_back(nd);
    if (mr) m_busy = 0;
    want_i = pend_i.size();
    want_d = pend_d.size();
    win = 0;
    if (m_busy == 0) begin
      if (want_i > 0 && want_d > 0) win = (m_last == 1) ? 2 : 1;
      else if (want_i > 0)          win = 1;
      else if (want_d > 0)          win = 2;
    end
    m_mv = (win != 0);
    if (win == 1) begin m_req = pend_i.pop_front(); m_busy = 1; m_last = 1; end
    if (win == 2) begin m_req = pend_d.pop_front(); m_busy = 2; m_last = 2; end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
  endtask

  // Requests only where the protocol allows: port not pending, and not in
  // flight unless completing this very cycle.
  task automatic run_rand(input int n, input int pv, input int pr);
    for (int k = 0; k < n; k++) begin
      bit mr, iv, dv;
      if (m_busy != 0) mr = !m_mv && ($urandom_range(99) < pr);
      else             mr = ($urandom_range(99) < 5);
      iv = (pend_i.size() == 0) && (m_busy != 1 || mr) && ($urandom_range(99) < pv);
      dv = (pend_d.size() == 0) && (m_busy != 2 || mr) && ($urandom_range(99) < pv);
      cyc(iv, $urandom, dv, $urandom, $urandom, 4'($urandom), 1'($urandom), mr, $urandom);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    m_reset();
    #3;
    chk_all_zero("por");
    #9 rst = 1'b1;

    // single data read, response three cycles after the request
    cyc(0, 0, 1, 32'h100, 0, 4'h0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h1111);
    chk("rd_mem_valid", {31'd0, mem_valid}, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("rd_dmem_rdata", dmem_rdata, 32'hDEADBEEF);
    idle(2);

    // contention straight after reset: data first, then instruction
    do_reset();
    cyc(1, 32'h0, 1, 32'h200, 32'h55, 4'hF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ct_first_addr", mem_addr, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ct_second_instr", {31'd0, mem_instr}, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A);

    // busy capture then back-to-back issue-on-ready on the data port
    cyc(0, 0, 1, 32'h300, 32'h77, 4'h3, 0, 0, 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
    cyc(0, 0, 1, 32'h500, 0, 0, 1, 1, 32'h2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_addr", mem_addr, 32'h500);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3);

    // full load, latency one: grants must alternate
    run_rand(40, 100, 100);
    idle(3);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 0, 0, m_busy != 0 && !m_mv, $urandom);

    // asynchronous reset while a data transaction is in flight
    cyc(0, 0, 1, 32'h600, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE;
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async");
    m_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF);

    run_rand(1500, 40, 50);
    run_rand(1500, 90, 30);
    run_rand(500, 15, 90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory-side port between the fetch requester (instruction port) and the execute/writebuffer requester (data port). The data port is the one whose ready stalls loads, stores and fences in execute.
- One transaction is outstanding at a time.
- Each requester gets a one-entry pending slot, so a one-cycle valid pulse is never lost while the port is busy.
- Arbitration is round-robin when both ports are pending.

Parameters:
- XLEN, 32, address and data width.
- DATA_FIRST, 1, which port wins the first contention after reset (1 = data, 0 = instruction).

Ports:
- rst  input  1  asynchronous, active-low reset.
- clk  input  1  clock; all state updates on posedge.
- imem_valid  input  1  instruction request pulse, one cycle.
- imem_addr  input  XLEN  instruction address.
- imem_rdata  output  XLEN  instruction read data.
- imem_ready  output  1  instruction completion, one cycle.
- dmem_valid  input  1  data request pulse, one cycle.
- dmem_instr  input  1  fetch attribute, forwarded to memory.
- dmem_addr  input  XLEN  data address.
- dmem_wdata  input  XLEN  store data.
- dmem_wstrb  input  XLEN/8  byte strobes; all zero means read.
- dmem_rdata  output  XLEN  data read data.
- dmem_ready  output  1  data completion, one cycle.
- mem_valid  output  1  memory request pulse, registered.
- mem_instr  output  1  1 = instruction fetch.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  memory write data.
- mem_wstrb  output  XLEN/8  memory byte strobes.
- mem_rdata  input  XLEN  memory read data.
- mem_ready  input  1  memory completion, one cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, both pending slots empty.
  - last_grant = instruction if DATA_FIRST=1, otherwise data.
  - All outputs 0.
- Capture: a valid pulse writes {addr, wdata, wstrb, instr} into that port's pending slot on the same edge. The instruction slot forces wdata=0, wstrb=0, instr=1.
- Protocol: a requester never pulses valid while its own slot is pending or in flight. The bench asserts this; RTL behaviour in that case is undefined.
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: instruction transaction in flight.
  - BUSY_D: data transaction in flight.
- Grant candidates are pending slots plus same-cycle valid inputs (bypass). Grant is evaluated:
  - in IDLE, or
  - in BUSY_x on the cycle mem_ready=1, excluding port x's just-completed request.
- Grant rules:
  - One candidate: grant it.
  - Two candidates: grant the port ≠ last_grant.
  - On grant: last_grant updates, the winner's slot clears, and state moves to BUSY_I or BUSY_D.
- mem_valid:
  - High for exactly one cycle, the cycle after the grant edge.
  - mem_addr, mem_wdata, mem_wstrb and mem_instr are registered and held stable until the next grant.
- Latency:
  - valid at cycle N with the memory idle → mem_valid at N+1.
  - mem_ready at M → a back-to-back grant gives mem_valid at M+1. No idle bubble beyond that.
- Completion:
  - xmem_ready = mem_ready & (state==BUSY_x), combinational.
  - xmem_rdata = mem_rdata when that port is in flight, else 0.
  - mem_ready in IDLE is ignored.
- Simultaneous valid on both ports in IDLE: winner per last_grant; the loser waits in its slot and is granted on the winner's mem_ready edge.
- Valid on the in-flight port in the same cycle as mem_ready: legal (issue-on-ready). It is captured and arbitrated normally against the other port.
- Reset mid-transaction: the in-flight request and pending slots are discarded. A mem_ready arriving after reset is ignored (state=IDLE).

Decomposition:
- Shared package (constants/wires): an arbiter state enum {IDLE, BUSY_I, BUSY_D} and a pending-slot struct {valid, instr, addr, wdata, wstrb} with an init constant.
- Reuse the existing memory request/response struct types on the memory-side port where the integrator prefers structs.
- Natural sub-module: mem_port_slot, the one-entry capture/clear register, instanced twice.

Test Plan:
- Single data read: dmem_valid at cycle 0, addr=0x100, wstrb=0 → mem_valid=1 at cycle 1 with mem_addr=0x100 and mem_instr=0. mem_ready at cycle 3 with mem_rdata=0xDEADBEEF → dmem_ready=1, dmem_rdata=0xDEADBEEF at cycle 3; imem_ready stays 0.
- Contention after reset (DATA_FIRST=1): both valid at cycle 0 (i addr=0x0, d addr=0x200, wstrb=0xF) → data granted first. mem_ready at cycle 2 → mem_valid at cycle 3 with mem_addr=0x0, mem_instr=1.
- Round-robin: both ports re-request every completion, memory latency 1 → grants alternate D, I, D, I across 8 transactions; no port is granted twice consecutively.
- Busy capture: imem_valid pulse while BUSY_D → held in slot. On the data mem_ready edge, mem_valid fires next cycle with the captured instruction address.
- Back-to-back on one port: dmem_valid in the same cycle as its own mem_ready → next mem_valid exactly one cycle later with the new address.
- Async reset mid-flight: rst=0 asserted between clock edges while BUSY_D → mem_valid and both ready outputs go 0 immediately. A later mem_ready produces no xmem_ready.
